// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I funct3
// encodings and the two-beat lane mask used for both aligned and split accesses.
package lsu_pkg;

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Low nibble: lanes of the addressed word; high nibble: lanes spilling into the next word.
  function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    return {4'b0000, size_mask(sz)} << off;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store shift/byte enables for up to two beats, and
// load lane select across two words followed by sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wd0,
  output logic [31:0] wd1,
  output logic        split,
  input  logic [31:0] ld_lo,
  input  logic [31:0] ld_hi,
  output logic [31:0] ld_data
);

  logic [7:0]  be;
  logic [63:0] wsh, wmask, rsh;
  logic [31:0] raw;

  always_comb begin
    be    = lane_mask(funct3[1:0], off);
    wsh   = {32'b0, st_data} << {off, 3'b000};
    wmask = '0;
    for (int i = 0; i < 8; i++) wmask[8*i +: 8] = {8{be[i]}};
    // Merge both beat words before extraction so split loads need no special case.
    rsh   = {ld_hi, ld_lo} >> {off, 3'b000};
    raw   = rsh[31:0];
    case (funct3[1:0])
      2'b00:   ld_data = {{24{raw[7]  & ~funct3[2]}}, raw[7:0]};
      2'b01:   ld_data = {{16{raw[15] & ~funct3[2]}}, raw[15:0]};
      default: ld_data = raw;
    endcase
  end

  assign be0   = be[3:0];
  assign be1   = be[7:4];
  assign wd0   = wsh[31:0]  & wmask[31:0];
  assign wd1   = wsh[63:32] & wmask[63:32];
  assign split = |be[7:4];

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: request handshake, one or two bus beats with wait-state
// tolerance and optional timeout. LSU_MISALIGNED_EN enables split misaligned accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-3:0] addr,
  output logic              re,
  output logic [3:0]        we,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  input  logic              bus_ready
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e      state;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdat_q, cap0_q;
  logic [TW-1:0] wait_cnt;

  logic        is_idle, accept, legal, go, strobe, beat_done, timed_out, beat_split;
  logic [2:0]  a_f3;
  logic [1:0]  a_off;
  logic [31:0] a_wd, ld_lo, ld_data, wd0, wd1;
  logic [3:0]  be0, be1;
  logic        split;

  // In IDLE the aligner sees the live request so beat 0 can launch on the accept edge.
  assign is_idle = (state == S_IDLE);
  assign a_f3    = is_idle ? req_funct3    : f3_q;
  assign a_off   = is_idle ? req_addr[1:0] : off_q;
  assign a_wd    = is_idle ? req_wdata     : wdat_q;
  assign ld_lo   = (state == S_BEAT1) ? cap0_q : rdata;

  lsu_align u_align (
    .funct3 (a_f3),
    .off    (a_off),
    .st_data(a_wd),
    .be0    (be0),
    .be1    (be1),
    .wd0    (wd0),
    .wd1    (wd1),
    .split  (split),
    .ld_lo  (ld_lo),
    .ld_hi  (rdata),
    .ld_data(ld_data)
  );

  assign req_ready = reset && is_idle;
  assign accept    = req_valid && req_ready;
  assign legal     = f3_legal(req_write, req_funct3);
`ifdef LSU_MISALIGNED_EN
  assign go         = legal;
  assign beat_split = split;
`else
  assign go         = legal && !split;
  assign beat_split = 1'b0;
`endif
  assign strobe    = re || (|we);
  assign beat_done = strobe && bus_ready;
  assign timed_out = (TIMEOUT > 0) && strobe && !bus_ready && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wr_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      wdat_q     <= '0;
      cap0_q     <= '0;
      wait_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      addr       <= '0;
      re         <= 1'b0;
      we         <= '0;
      wdata      <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      case (state)
        S_IDLE: if (accept) begin
          wr_q     <= req_write;
          f3_q     <= req_funct3;
          off_q    <= req_addr[1:0];
          wdat_q   <= req_wdata;
          wait_cnt <= '0;
          if (go) begin
            state <= S_BEAT0;
            addr  <= req_addr[ADDR_W-1:2];
            re    <= !req_write;
            we    <= req_write ? be0 : 4'b0000;
            wdata <= req_write ? wd0 : 32'b0;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
          end
        end
        S_BEAT0, S_BEAT1: begin
          if (beat_done) begin
            wait_cnt <= '0;
            if (state == S_BEAT0 && beat_split) begin
              state  <= S_BEAT1;
              cap0_q <= rdata;
              addr   <= addr + 1'b1;
              we     <= wr_q ? be1 : 4'b0000;
              wdata  <= wr_q ? wd1 : 32'b0;
            end else begin
              state      <= S_RESP;
              addr       <= '0;
              re         <= 1'b0;
              we         <= '0;
              wdata      <= '0;
              resp_valid <= 1'b1;
              resp_rdata <= wr_q ? 32'b0 : ld_data;
            end
          end else if (timed_out) begin
            // Abandon the access, including any beat not yet issued.
            state      <= S_RESP;
            wait_cnt   <= '0;
            addr       <= '0;
            re         <= 1'b0;
            we         <= '0;
            wdata      <= '0;
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
          end else if (TIMEOUT > 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus random traffic against a
// byte-addressed reference memory and a latency/fault model of the access rules.
module tb_lsu;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;
`ifdef LSU_MISALIGNED_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [29:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] wdata, rdata;
  logic        bus_ready;

  int checks   = 0;
  int failures = 0;

  lsu #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .addr(addr), .re(re), .we(we), .wdata(wdata), .rdata(rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] bus_mem [logic [29:0]];
  logic [7:0]  ref_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return {wa[13:0], 2'b01, wa[15:0]} ^ 32'h5A3C_9617;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [29:0] wa);
    if (bus_mem.exists(wa)) return bus_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] ba);
    logic [31:0] w;
    if (ref_mem.exists(ba)) return ref_mem[ba];
    w = init_word(ba[31:2]);
    return w[8*ba[1:0] +: 8];
  endfunction

  task automatic set_word(input logic [29:0] wa, input logic [31:0] v);
    bus_mem[wa] = v;
    for (int i = 0; i < 4; i++) ref_mem[{wa, 2'(i)}] = v[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request and acts as the bus responder until the response pulse.
  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int waits,
                        output logic [31:0] rd, output logic flt, output int lat,
                        output int nbeats, output logic [29:0] a0, output logic [29:0] a1,
                        output logic [3:0] we0, output logic [31:0] wd0);
    int cnt;
    bit done;
    logic [29:0] sa;
    logic [4:0]  sc;
    logic [31:0] sw, tmp;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; nbeats = 0; cnt = 0; done = 0;
    rd = 'x; flt = 'x; a0 = '0; a1 = '0; we0 = '0; wd0 = '0;
    sa = '0; sc = '0; sw = '0;
    while (!done && lat < 60) begin
      bus_ready = 1'b0;
      rdata = $urandom;
      if (resp_valid) begin
        rd = resp_rdata; flt = resp_fault; done = 1;
        chk("no_strobe_in_resp", {27'b0, re, we}, 32'd0);
      end else if (re || we != 4'b0) begin
        if (cnt == 0) begin
          sa = addr; sc = {re, we}; sw = wdata;
          if (nbeats == 0) begin a0 = addr; we0 = we; wd0 = wdata; end
          else a1 = addr;
        end else begin
          chk("hold_addr", {2'b0, addr}, {2'b0, sa});
          chk("hold_ctl", {27'b0, re, we}, {27'b0, sc});
          chk("hold_wdata", wdata, sw);
        end
        if (cnt < waits) cnt++;
        else begin
          bus_ready = 1'b1;
          if (re) rdata = bus_rd(addr);
          tmp = bus_rd(addr);
          for (int k = 0; k < 4; k++) if (we[k]) tmp[8*k +: 8] = wdata[8*k +: 8];
          if (we != 4'b0) bus_mem[addr] = tmp;
          nbeats++;
          cnt = 0;
        end
      end
      if (!done) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
    end
    bus_ready = 1'b0;
    if (!done) chk("resp_never_arrived", 32'd0, 32'd1);
  endtask

  // Reference: byte-level semantics of RV32I loads/stores with the unit's latency rules.
  task automatic model_op(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int waits,
                          output logic [31:0] rd, output logic [29:0] a0,
                          output logic [3:0] we0, output logic [31:0] wd0);
    logic flt;
    int lat, nb, n, beats;
    logic [29:0] a1;
    bit legal, mis, bus;
    logic [31:0] v, ba;
    run_op(w, f3, a, wd, waits, rd, flt, lat, nb, a0, a1, we0, wd0);
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n     = 1 << f3[1:0];
    mis   = (int'(a[1:0]) + n) > 4;
    bus   = legal && (!mis || MIS_EN);
    beats = bus ? (mis ? 2 : 1) : 0;
    chk({tag, "_latency"}, lat, bus ? 1 + beats * (waits + 1) : 1);
    chk({tag, "_fault"}, {31'b0, flt}, {31'b0, !bus});
    chk({tag, "_beats"}, nb, beats);
    if (bus) chk({tag, "_addr0"}, {2'b0, a0}, {2'b0, a[31:2]});
    if (beats == 2) chk({tag, "_addr1"}, {2'b0, a1}, {2'b0, a[31:2] + 30'd1});
    v = 32'b0;
    if (bus && !w) begin
      for (int i = 0; i < n; i++) begin
        ba = a + 32'(i);
        v |= 32'(ref_byte(ba)) << (8 * i);
      end
      if (!f3[2] && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    end
    chk({tag, "_rdata"}, rd, v);
    if (bus && w) begin
      for (int i = 0; i < n; i++) begin
        ba = a + 32'(i);
        ref_mem[ba] = wd[8*i +: 8];
      end
      for (int j = 0; j < beats; j++) begin
        logic [29:0] wa;
        wa = a[31:2] + 30'(j);
        for (int k = 0; k < 4; k++) begin
          logic [31:0] bw;
          bw = bus_rd(wa);
          chk({tag, "_mem"}, {24'b0, bw[8*k +: 8]}, {24'b0, ref_byte({wa, 2'(k)})});
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] rd, wd0, a;
    logic [29:0] a0, a1;
    logic [3:0]  we0;
    logic        flt;
    int          lat, nb;

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rdata = '0; bus_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp", {30'b0, resp_valid, resp_fault}, 32'd0);
    chk("rst_strobes", {27'b0, re, we}, 32'd0);
    chk("rst_addr", {2'b0, addr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_req_ready", {31'b0, req_ready}, 32'd1);

    set_word(30'h40, 32'hDEADBEEF);
    model_op("lw_aligned", 1'b0, 3'b010, 32'h100, 32'h0, 0, rd, a0, we0, wd0);
    chk("lw_value", rd, 32'hDEADBEEF);
    chk("lw_addr", {2'b0, a0}, 32'h40);

    model_op("sb_wait3", 1'b1, 3'b000, 32'h103, 32'h123456AB, 3, rd, a0, we0, wd0);
    chk("sb_we", {28'b0, we0}, 32'h8);
    chk("sb_wdata", wd0, 32'hAB000000);

    set_word(30'h40, 32'h00800000);
    model_op("lb_neg", 1'b0, 3'b000, 32'h102, 32'h0, 1, rd, a0, we0, wd0);
    chk("lb_value", rd, 32'hFFFFFF80);
    set_word(30'h40, 32'h80010000);
    model_op("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 0, rd, a0, we0, wd0);
    chk("lhu_value", rd, 32'h00008001);

    set_word(30'h40, 32'h44332211);
    set_word(30'h41, 32'h88776655);
    model_op("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 0, rd, a0, we0, wd0);
    chk("lw_mis_value", rd, MIS_EN ? 32'h55443322 : 32'h0);

    set_word(30'h3FFFFFFF, 32'hA1B2C3D4);
    set_word(30'h0, 32'h11223344);
    model_op("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFD, 32'h0, 1, rd, a0, we0, wd0);
    model_op("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D, 0, rd, a0, we0, wd0);
    model_op("ld_illegal", 1'b0, 3'b110, 32'h200, 32'h0, 0, rd, a0, we0, wd0);
    model_op("st_illegal", 1'b1, 3'b100, 32'h200, 32'h55, 0, rd, a0, we0, wd0);

    run_op(1'b0, 3'b010, 32'h300, 32'h0, 1000, rd, flt, lat, nb, a0, a1, we0, wd0);
    chk("to_latency", lat, 1 + TIMEOUT);
    chk("to_fault", {31'b0, flt}, 32'd1);
    chk("to_rdata", rd, 32'd0);

    // Reset while a read beat is stalled.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; bus_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_re", {31'b0, re}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_re", {31'b0, re}, 32'd0);
    chk("mid_rst_addr", {2'b0, addr}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    reset = 1'b1;
    #1;
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    set_word(30'h100, 32'h0BADF00D);
    model_op("lw_after_rst", 1'b0, 3'b010, 32'h400, 32'h0, 2, rd, a0, we0, wd0);
    chk("lw_after_rst_value", rd, 32'h0BADF00D);

    for (int t = 0; t < 200; t++) begin
      a = 32'h2000 + 32'($urandom_range(0, 47));
      model_op("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
               $urandom_range(0, TIMEOUT - 1), rd, a0, we0, wd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit replacing the single-cycle memory adapter between the multi-cycle core and the word-addressed memory bus. Accepts one RV32I load or store per request, drives the bus with a ready handshake tolerating any number of wait states, and performs lane alignment, byte-enable generation, sign/zero extension, misaligned-access handling and an optional bus timeout. Sits between the control/datapath (request/response side) and the external `rdata`/`wdata`/`addr`/`re`/`we` bus.

## Interface
- `ADDR_W`, 32: byte-address width; bus word address is `ADDR_W-2` bits.
- `TIMEOUT`, 0: max wait cycles per bus beat before fault; 0 disables the timeout.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  high only in IDLE; request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data (rs2).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  valid with `resp_valid`: illegal funct3, misalignment (macro off) or timeout.
- `addr`  out  ADDR_W-2  bus word address.
- `re`  out  1  bus read strobe.
- `we`  out  4  bus byte write enables.
- `wdata`  out  32  lane-shifted store data; unused lanes 0.
- `rdata`  in  32  bus read data, valid in the cycle `bus_ready` is high.
- `bus_ready`  in  1  completes the current beat.

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: on accept, latch request; legal and aligned (or split allowed) -> BEAT0; otherwise -> RESP with fault, no bus activity.
- Illegal funct3: loads 011/110/111, stores 011 and 1xx.
- BEAT0/BEAT1: drive `addr`, `re` (load) or `we` (store); hold them stable until `bus_ready` is high; capture `rdata` on that cycle. BEAT0 -> BEAT1 if split, else -> RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Store lanes: byte at offset k -> `we`=1<<k, data<<8k; half at offset 0/2 -> `we` 0011/1100; word -> 1111.
- Loads: select lane by offset; LB/LH sign-extend, LBU/LHU zero-extend.
- Misaligned: half at offset 3, word at offset 1..3.
- Timeout (TIMEOUT>0): per-beat wait counter counts cycles with strobe high and `bus_ready` low; reaching TIMEOUT drops strobes the next cycle -> RESP with fault; remaining beat skipped.
- Reset (any state): all outputs 0 immediately, state IDLE, in-flight access abandoned without response.

## Timing
- Reset values: `req_ready` 1 after release; `resp_valid`, `resp_fault`, `re`, `we`, `addr`, `wdata`, `resp_rdata` all 0.
- Accept in cycle 0 -> strobe in cycle 1 -> zero-wait `bus_ready` in cycle 1 -> `resp_valid` in cycle 2. Each wait state adds 1; split adds one beat.
- Fault without bus access: `resp_valid` in cycle 1.
- Strobes never asserted in IDLE or RESP; `resp_rdata` held stable only during the `resp_valid` cycle.
- Split beat1 word address = beat0 + 1, modulo 2^(ADDR_W-2); wraps top to 0.

## Configuration
- `LSU_MISALIGNED_EN` defined: misaligned accesses split into two beats. Low bytes come from word A>>2 and high bytes from the next word; byte enables are split per beat. Load data is assembled before extension. `resp_fault`=0 unless a timeout occurs.
- Undefined: misaligned accesses fault immediately with no bus activity; BEAT1 unreachable.

## Structure
- Package `lsu_pkg`: state enum, funct3 constants, lane/byte-enable helper functions.
- Sub-module `lsu_align`: combinational store lane shift and byte-enable generation, load lane select, split merge and extension; the FSM, wait counter and capture registers stay in `lsu`.

## Test plan
- LW at 0x100, `rdata`=0xDEADBEEF, zero wait -> `addr`=0x40, `re` in cycle 1, `resp_valid` in cycle 2, `resp_rdata`=0xDEADBEEF, fault 0.
- SB 0xAB at 0x103 with 3 wait states -> `we`=1000 and `wdata`=0xAB000000 held 4 cycles, `resp_valid` in cycle 5.
- LB at 0x102, `rdata`=0x00800000 -> 0xFFFFFF80; LHU at 0x102, `rdata`=0x80010000 -> 0x00008001.
- LW at 0x101 with macro defined, beat `rdata` 0x44332211 then 0x88776655 -> `addr` 0x40 then 0x41, result 0x55443322. With macro undefined -> fault in cycle 1, no strobe.
- TIMEOUT=4, `bus_ready` held low -> strobe drops after 4 wait cycles, `resp_valid` with fault 1. Illegal funct3 110 load -> fault, no strobe.
- `reset` low during BEAT0 wait -> `re`=0 immediately, no `resp_valid`; after release `req_ready`=1 and the next LW completes normally.
